// File: rtl/xdebouncer_multi_if.sv
// ---------------------------------------------------------------------------
// xdebouncer_multi_if : button bus between raw inputs and the debouncer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface xdebouncer_multi_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] btn_in;
  logic            ready;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;

  modport master (
    output btn_in,
    input  ready, btn_level, btn_press, btn_release
  );

  modport slave (
    input  btn_in,
    output ready, btn_level, btn_press, btn_release
  );
endinterface

`default_nettype wire

// File: rtl/xdebouncer_multi.sv
// ---------------------------------------------------------------------------
// xdebouncer_multi : startup settle timer plus one debounce engine per button
// Optional: DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser per channel.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xdebouncer_multi #(
  parameter int                N_CH        = 5,
  parameter int                CNT_W       = 20,
  parameter int unsigned       STABLE_CNT  = 500000,
  parameter logic [CNT_W-1:0]  STARTUP_CNT = 20'hFFFFF
) (
  input  wire               clk,
  input  wire               rst,
  xdebouncer_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  logic [CNT_W-1:0]           startup_cnt;
  logic                       ready;
  logic [N_CH-1:0]            s;
  logic [N_CH-1:0][CNT_W-1:0] cnt;
  logic [N_CH-1:0]            lvl;
  logic [N_CH-1:0]            prs;
  logic [N_CH-1:0]            rls;

  always_ff @(posedge clk) begin
    if (rst) begin
      startup_cnt <= STARTUP_CNT;
    end else if (startup_cnt != '0) begin
      startup_cnt <= startup_cnt - CNT_W'(1);
    end
  end

  assign ready = (startup_cnt == '0);

`ifdef DEBOUNCE_SYNC_EN
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  // Synchroniser keeps running during startup so it is settled when ready rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = bus.btn_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lvl <= '0;
      prs <= '0;
      rls <= '0;
    end else begin
      prs <= '0;
      rls <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (!ready) begin
          cnt[i] <= '0;
          lvl[i] <= 1'b0;
        end else if (s[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == STABLE_LAST) begin
          lvl[i] <= s[i];
          cnt[i] <= '0;
          prs[i] <= s[i];
          rls[i] <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.btn_level   = lvl;
  assign bus.btn_press   = prs;
  assign bus.btn_release = rls;

endmodule

`default_nettype wire

// File: tb/tb_xdebouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_xdebouncer_multi : directed vector table plus hand sequences for xdebouncer_multi
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xdebouncer_multi;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 8;
  localparam int STABLE  = 4;
  localparam int STARTUP = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif
  localparam int LAT = STABLE + LAG;

  typedef struct {
    logic [1:0] btn;
    logic       rdy;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vq[$];

  xdebouncer_multi_if #(.N_CH(N_CH)) bus ();

  xdebouncer_multi #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .STABLE_CNT (STABLE),
    .STARTUP_CNT(CNT_W'(STARTUP))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] btn, input logic rdy, input logic [1:0] lvl,
                     input logic [1:0] prs, input logic [1:0] rls, input int n);
    for (int k = 0; k < n; k++) vq.push_back('{btn, rdy, lvl, prs, rls});
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic [1:0] lvl,
                            input logic [1:0] prs, input logic [1:0] rls);
    check({tag, ".ready"},   32'(bus.ready),       32'(rdy));
    check({tag, ".level"},   32'(bus.btn_level),   32'(lvl));
    check({tag, ".press"},   32'(bus.btn_press),   32'(prs));
    check({tag, ".release"}, 32'(bus.btn_release), 32'(rls));
  endtask

  initial begin
    // Startup: ready low for 7 edges, high after the 8th.
    add(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 7);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1);
    // Three-cycle glitch on channel 0 is rejected.
    add(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 3);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2);
    // Held press: level rises on the 4th edge, then a release 4 edges after dropping.
    add(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 3);
    add(2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 1);
    add(2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 1);
    add(2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 3);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 1);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1);
    // Channel 0 held, channel 1 bounces 1,0,1,1,1,1.
    add(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1);
    add(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1);
    add(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1);
    add(2'b11, 1'b1, 2'b01, 2'b01, 2'b00, 1);
    add(2'b11, 1'b1, 2'b01, 2'b00, 2'b00, 1);
    add(2'b11, 1'b1, 2'b11, 2'b10, 2'b00, 1);
    add(2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 1);
    // Simultaneous release on both channels.
    add(2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 3);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b11, 1);
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1);

    bus.btn_in = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    check_outs("reset", 1'b0, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // Inputs are driven LAG steps early so the sampled value lines up with the table.
    for (int k = 0; k < vq.size(); k++) begin
      int j;
      j = (k + LAG < vq.size()) ? k + LAG : vq.size() - 1;
      bus.btn_in = vq[j].btn;
      tick();
      check_outs($sformatf("vec%0d", k + 1), vq[k].rdy, vq[k].lvl, vq[k].prs, vq[k].rls);
    end

    // Button held through startup: press 4 edges after ready rises.
    bus.btn_in = 2'b01;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= STARTUP + STABLE + 1; k++) begin
      tick();
      check_outs($sformatf("held%0d", k), (k >= STARTUP),
                 (k >= STARTUP + STABLE) ? 2'b01 : 2'b00,
                 (k == STARTUP + STABLE) ? 2'b01 : 2'b00, 2'b00);
    end

    // Build up a partial release count of 3, then reset discards it.
    bus.btn_in = 2'b00;
    for (int k = 1; k <= STABLE - 1 + LAG; k++) begin
      tick();
      check_outs($sformatf("partial%0d", k), 1'b1, 2'b01, 2'b00, 2'b00);
    end
    rst = 1'b1;
    tick();
    check_outs("midrst", 1'b0, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= STARTUP; k++) begin
      tick();
      check_outs($sformatf("restart%0d", k), (k == STARTUP), 2'b00, 2'b00, 2'b00);
    end

    // End-to-end latency from raw input, including any synchroniser stages.
    bus.btn_in = 2'b01;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check_outs($sformatf("lat%0d", k), 1'b1,
                 (k >= LAT) ? 2'b01 : 2'b00,
                 (k == LAT) ? 2'b01 : 2'b00, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
